lz_word_feeder: RTL and testbench
=================================

// Module: lz_word_feeder
// PURPOSE
//   Upstream stage of the leading-zero counter. Accepts one packed word of WORD chunks
//   (WIDTH bits each) per valid/ready handshake and emits it MSB chunk first, one chunk
//   per cycle, on the counter's ivalid/mode/data inputs. In turbo mode it stops the word
//   after the first non-zero chunk. A one-entry pending buffer lets words stream with no bubble.
// PARAMETERS
//   WIDTH  8  bits per chunk; must match the counter's WIDTH (legal values 4/8/16)
//   WORD   4  chunks per word; must match the counter's WORD (>=1)
// PORTS
//   CLK        in   1             single clock, rising edge
//   rst_n      in   1             asynchronous, active-low reset
//   in_valid   in   1             upstream word valid
//   in_ready   out  1             feeder can take a word; = !pend_valid (combinational)
//   in_mode    in   1             0 = normal (all chunks sent), 1 = turbo (early stop)
//   in_word    in   WIDTH*WORD    packed word; chunk 0 = in_word[WIDTH*WORD-1 -: WIDTH]
//   out_valid  out  1             drives counter ivalid
//   out_mode   out  1             drives counter mode; constant for the whole word
//   out_data   out  WIDTH         drives counter data
//   busy       out  1             active word or pending word held
// BEHAVIOUR
//   - Reset: out_valid=0, out_mode=0, out_data=0, busy=0, pend_valid=0, idx=0, state=IDLE.
//     in_ready is 1 right after reset. Reset mid-word drops the active and pending words.
//   - Accept: on the rising edge where in_valid && in_ready. {in_word,in_mode} are captured.
//   - Registers: active word/mode, chunk index idx (0..WORD-1), pending word/mode + pend_valid.
//   - FSM IDLE: out_valid=0, out_data=0. On accept, load chunk 0 straight to the outputs
//     (latency 1: out_valid goes high after the accepting edge). Go to SEND with idx=0.
//   - FSM SEND: out_valid=1. The word is ending when idx==WORD-1, or when out_mode==1
//     and out_data!=0.
//     . not ending: idx++, out_data = next chunk.
//     . ending and pend_valid: load the pending word's chunk 0, clear pend_valid, stay
//       in SEND (no bubble).
//     . ending, no pending word, accept this edge: load the incoming chunk 0 directly,
//       stay in SEND.
//     . ending, nothing available: go to IDLE and clear out_valid/out_data.
//   - In SEND, an accept with no word ending loads the pending buffer; in_ready then falls.
//   - Pending full: in_ready=0. Only one word is pending; no overwrite is possible.
//   - All-zero word in turbo mode: all WORD chunks are sent (no non-zero chunk to stop on).
//   - Width rules: idx is $clog2(WORD) bits, minimum 1. Chunk select is
//     word[WIDTH*(WORD-1-idx) +: WIDTH].
//   - busy = (state==SEND) || pend_valid.
// STRUCTURE
//   - Shared package lz_pkg: default LZ_WIDTH=8, LZ_WORD=4; state encoding IDLE=2'b00, SEND=2'b01.
//     The counter's localparams move there too.
//   - Sub-module lz_pend_buf: one-entry holding register (word+mode, valid, ready).
//     The FSM, index counter and output registers stay in lz_word_feeder.
// TESTING (WIDTH=8, WORD=4; counter connected downstream where noted)
//   1 Normal word 32'h00001F80, mode 0 -> out_data 00,00,1F,80 on 4 consecutive
//     cycles, then out_valid=0. Counter reports zero=19.
//   2 Same word, mode 1 -> 00,00,1F (3 cycles), out_valid drops, 80 is never sent.
//   3 Word 32'h0 in turbo -> 4 chunks of 00 with out_mode=1. Counter reports zero=32.
//   4 in_valid held with words A=32'h01020304, B=32'hFF000000, C=32'h0 ->
//     12 consecutive out_valid cycles with no gap. in_ready=0 while a word is pending.
//     A handshake never succeeds when in_ready=0.
//   5 rst_n pulsed low during chunk 2 of a word with another word pending ->
//     all outputs 0 asynchronously, in_ready=1 after release, the next word starts at chunk 0.
//   6 Single accept in IDLE -> out_valid rises exactly 1 cycle after the accepting edge,
//     busy=1 until the edge after the last chunk.

Source files
------------

// File: rtl/lz_pkg.sv
// Shared definitions for the leading-zero counter datapath and its word feeder.
package lz_pkg;

    localparam int unsigned LZ_WIDTH = 8;
    localparam int unsigned LZ_WORD  = 4;
    // Counter result width: zero count ranges 0..LZ_WIDTH*LZ_WORD inclusive.
    localparam int unsigned LZ_CNT_W = $clog2(LZ_WIDTH * LZ_WORD + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01
    } lz_state_e;

    function automatic int unsigned lz_idx_w(input int unsigned word);
        return (word > 1) ? $clog2(word) : 1;
    endfunction

endpackage

// File: rtl/lz_pend_buf.sv
// One-entry holding register for a word (plus mode) waiting behind the active word.
module lz_pend_buf
    import lz_pkg::*;
#(
    parameter int unsigned W = LZ_WIDTH * LZ_WORD
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] word_i,
    input  logic         mode_i,
    output logic         valid_o,
    output logic         ready_o,
    output logic [W-1:0] word_o,
    output logic         mode_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] word_q, word_d;
    logic         mode_q, mode_d;

    // Load has priority; a clear and a load never coincide because load requires an empty slot.
    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        mode_d  = mode_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            word_d  = word_i;
            mode_d  = mode_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
        end
    end

    assign valid_o = valid_q;
    assign ready_o = !valid_q;
    assign word_o  = word_q;
    assign mode_o  = mode_q;

endmodule

// File: rtl/lz_word_feeder.sv
// Serialises packed words MSB chunk first into the leading-zero counter, with optional
// early stop after the first non-zero chunk and a pending slot for bubble-free streaming.
module lz_word_feeder
    import lz_pkg::*;
#(
    parameter int unsigned WIDTH = LZ_WIDTH,
    parameter int unsigned WORD  = LZ_WORD
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [WIDTH*WORD-1:0] in_word,
    output logic                  out_valid,
    output logic                  out_mode,
    output logic [WIDTH-1:0]      out_data,
    output logic                  busy
);

    localparam int unsigned WORD_W = WIDTH * WORD;
    localparam int unsigned IDX_W  = lz_idx_w(WORD);

    lz_state_e          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               mode_q, mode_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               busy_q, busy_d;

    logic               pend_valid, pend_ready, pend_mode;
    logic [WORD_W-1:0]  pend_word;
    logic               pend_load, pend_clr;
    logic               accept, ending;

    function automatic logic [WIDTH-1:0] chunk(input logic [WORD_W-1:0] w,
                                               input logic [IDX_W-1:0]  i);
        logic [WORD_W-1:0] s;
        s = w << (WIDTH * 32'(i));
        return s[WORD_W-1 -: WIDTH];
    endfunction

    lz_pend_buf #(.W(WORD_W)) u_pend (
        .clk     (CLK),
        .rst_n   (rst_n),
        .load_i  (pend_load),
        .clear_i (pend_clr),
        .word_i  (in_word),
        .mode_i  (in_mode),
        .valid_o (pend_valid),
        .ready_o (pend_ready),
        .word_o  (pend_word),
        .mode_o  (pend_mode)
    );

    assign in_ready = pend_ready;
    assign accept   = in_valid && pend_ready;
    assign ending   = (32'(idx_q) == WORD - 1) || (mode_q && (out_data_q != '0));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        word_d      = word_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        pend_load   = 1'b0;
        pend_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = SEND;
                    idx_d       = '0;
                    word_d      = in_word;
                    mode_d      = in_mode;
                    out_valid_d = 1'b1;
                    out_data_d  = chunk(in_word, '0);
                end
            end
            SEND: begin
                if (!ending) begin
                    idx_d      = IDX_W'(idx_q + 1'b1);
                    out_data_d = chunk(word_q, IDX_W'(idx_q + 1'b1));
                    pend_load  = accept;
                end else if (pend_valid) begin
                    // Back-to-back handoff from the pending slot keeps out_valid high.
                    idx_d      = '0;
                    word_d     = pend_word;
                    mode_d     = pend_mode;
                    out_data_d = chunk(pend_word, '0);
                    pend_clr   = 1'b1;
                end else if (accept) begin
                    idx_d      = '0;
                    word_d     = in_word;
                    mode_d     = in_mode;
                    out_data_d = chunk(in_word, '0);
                end else begin
                    state_d     = IDLE;
                    idx_d       = '0;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_data_d  = '0;
            end
        endcase
        busy_d = (state_d == SEND) || (pend_valid && !pend_clr) || pend_load;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            word_q      <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mode  = mode_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lz_word_feeder.sv
// Scoreboard bench for lz_word_feeder: accepted words expand into expected chunk streams.
module tb_lz_word_feeder;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned WORD  = 4;

    logic                  CLK = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [WIDTH*WORD-1:0] in_word;
    logic                  out_valid;
    logic                  out_mode;
    logic [WIDTH-1:0]      out_data;
    logic                  busy;

    int tests = 0;
    int fails = 0;
    int cur_run = 0;
    int max_run = 0;
    logic [WIDTH:0] exp_q[$];

    lz_word_feeder #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_mode  (out_mode),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: chunks leave MSB first; turbo stops right after the first non-zero chunk.
    function automatic void model_push(input logic [WIDTH*WORD-1:0] w, input logic m);
        for (int i = 0; i < WORD; i++) begin
            logic [WIDTH-1:0] c;
            c = w[WIDTH*WORD-1-WIDTH*i -: WIDTH];
            exp_q.push_back({m, c});
            if (m && c != 0) break;
        end
    endfunction

    always @(posedge CLK) begin
        if (rst_n && in_valid && in_ready) model_push(in_word, in_mode);
    end

    always @(negedge rst_n) exp_q.delete();

    always @(negedge CLK) begin
        if (rst_n) begin
            if (out_valid) begin
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_chunk: got data %0h mode %0b, none expected",
                             out_data, out_mode);
                end else begin
                    logic [WIDTH:0] e;
                    e = exp_q.pop_front();
                    check("chunk_mode_data", {out_mode, out_data}, e);
                end
            end else begin
                cur_run = 0;
                check("idle_data_zero", out_data, 0);
            end
        end
    end

    task automatic push_word(input logic [WIDTH*WORD-1:0] w, input logic m);
        logic rdy;
        int   n;
        in_word  = w;
        in_mode  = m;
        in_valid = 1'b1;
        n = 0;
        do begin
            rdy = in_ready;
            @(posedge CLK);
            #1;
            n++;
        end while (!rdy && n < 100);
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no accept, required one within 100 cycles");
        end
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("drain_in_time", (n < 200), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before 2ms");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_word  = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_mode", out_mode, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;

        // Latency and busy window of a single normal word.
        check("idle_no_valid", out_valid, 0);
        max_run = 0;
        push_word(32'h00001F80, 1'b0);
        in_valid = 1'b0;
        check("lat1_valid", out_valid, 1);
        check("lat1_busy", busy, 1);
        check("lat1_chunk0", out_data, 8'h00);
        repeat (3) @(posedge CLK);
        #1;
        check("last_chunk_busy", busy, 1);
        check("last_chunk_data", out_data, 8'h80);
        @(posedge CLK);
        #1;
        check("after_last_busy", busy, 0);
        check("after_last_valid", out_valid, 0);
        drain();
        check("normal_len", max_run, 4);

        // Turbo stops after the 1F chunk.
        max_run = 0;
        push_word(32'h00001F80, 1'b1);
        drain();
        check("turbo_len", max_run, 3);

        // All-zero turbo word still sends every chunk.
        max_run = 0;
        push_word(32'h00000000, 1'b1);
        drain();
        check("turbo_zero_len", max_run, 4);

        // Streaming three words with in_valid held high.
        max_run = 0;
        push_word(32'h01020304, 1'b0);
        push_word(32'hFF000000, 1'b0);
        check("pend_full_ready", in_ready, 0);
        check("pend_full_busy", busy, 1);
        push_word(32'h00000000, 1'b0);
        drain();
        check("stream_no_gap_len", max_run, 12);

        // Asynchronous reset during chunk 2 with a word pending.
        push_word(32'hA1B2C3D4, 1'b0);
        push_word(32'h11223344, 1'b0);
        in_valid = 1'b0;
        @(posedge CLK);
        #1;
        check("pre_rst_chunk2", out_data, 8'hC3);
        check("pre_rst_pending", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 1);
        #3;
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_idle", out_valid, 0);
        push_word(32'h55667788, 1'b0);
        in_valid = 1'b0;
        check("post_rst_chunk0", out_data, 8'h55);
        drain();

        // Randomised words with sparse non-zero chunks and random gaps.
        for (int k = 0; k < 300; k++) begin
            logic [WIDTH*WORD-1:0] w;
            for (int c = 0; c < WORD; c++) begin
                w[WIDTH*c +: WIDTH] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            end
            push_word(w, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 5)) @(posedge CLK);
                #1;
            end
        end
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
